// File: rtl/rr_handshake_arbiter.sv
// rr_handshake_arbiter: N-way round-robin arbiter in front of a single
// registered valid/ready output stage. Search starts at rr_ptr and wraps
// modulo N; the pointer advances past each winner.
// Optional grant counters (16-bit, saturating) are built only when the
// ARB_GNT_CNT_EN macro is defined; otherwise the gnt_cnt port is absent.
module rr_handshake_arbiter #(
  parameter int N      = 4,
  parameter int DATA_W = 3,
  parameter int ID_W   = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [N-1:0]        s_valid,
  input  logic [N*DATA_W-1:0] s_data,
  output logic [N-1:0]        s_ready,
  output logic                m_valid,
  output logic [DATA_W-1:0]   m_data,
  output logic [ID_W-1:0]     m_id,
  input  logic                m_ready
`ifdef ARB_GNT_CNT_EN
  ,
  output logic [N*16-1:0]     gnt_cnt
`endif
);

  localparam logic [ID_W:0] N_W = (ID_W+1)'(N);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [ID_W-1:0]   m_id_q,    m_id_d;
  logic [ID_W-1:0]   rr_ptr_q,  rr_ptr_d;

  logic              load;
  logic              any_valid;
  logic              accept;
  logic [ID_W-1:0]   winner;
  logic [DATA_W-1:0] win_data;

  // Rotate requests so rr_ptr sits at bit 0, take the first set bit, then
  // map the offset back to an absolute index with an explicit modulo-N wrap.
  always_comb begin
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [ID_W-1:0] off;
    logic [ID_W:0]   sum;
    logic            found;
    dbl   = {s_valid, s_valid} >> rr_ptr_q;
    rot   = dbl[N-1:0];
    off   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[0]) begin
        found = 1'b1;
        off   = ID_W'(k);
      end
      rot = rot >> 1;
    end
    sum = {1'b0, rr_ptr_q} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    winner = sum[ID_W-1:0];
  end

  // Select the winner's payload from the packed input bus.
  always_comb begin
    logic [N*DATA_W-1:0] sh;
    sh       = s_data >> (32'(winner) * DATA_W);
    win_data = sh[DATA_W-1:0];
  end

  assign any_valid = |s_valid;
  assign load      = !m_valid_q || m_ready;
  assign accept    = load && any_valid && sys_rst_n;

  // Single accept strobe toward the winning requester.
  always_comb begin
    s_ready = '0;
    if (accept) s_ready = N'(1) << winner;
  end

  // Output stage: load on accept, empty on drain without refill, else hold.
  always_comb begin
    logic [ID_W:0] nxt;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_id_d    = m_id_q;
    rr_ptr_d  = rr_ptr_q;
    nxt       = {1'b0, winner} + (ID_W+1)'(1);
    if (nxt >= N_W) nxt = '0;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = win_data;
      m_id_d    = winner;
      rr_ptr_d  = nxt[ID_W-1:0];
    end else if (load) begin
      m_valid_d = 1'b0;
    end
  end

  // Output stage and round-robin pointer registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_id_q    <= '0;
      rr_ptr_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_id_q    <= m_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_id    = m_id_q;

`ifdef ARB_GNT_CNT_EN
  for (genvar g = 0; g < N; g++) begin : g_cnt
    logic [15:0] cnt_q, cnt_d;

    // Count accepts of requester g, sticking at all-ones.
    always_comb begin
      cnt_d = cnt_q;
      if (s_ready[g] && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) cnt_q <= '0;
      else            cnt_q <= cnt_d;
    end

    assign gnt_cnt[g*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: doc/rr_handshake_arbiter.md
Name: rr_handshake_arbiter

Overview:
- N-requester round-robin arbiter sharing one valid/ready consumer (the slave-side handshake datapath) between several masters.
- Each requester presents valid + DATA_W data. The arbiter selects one per accept slot and registers the winner's data into a single output stage.
- The output stage drives valid/data/id downstream and holds them until the consumer asserts ready.
- Sits between multiple master instances and one slave instance in the handshake top level.

Parameters:
- N, 4, number of requesters (2..8)
- DATA_W, 3, payload width per requester
- ID_W, 2, width of granted-requester index; N <= 2**ID_W required

Ports:
- sys_clk  input  1  system clock, rising edge
- sys_rst_n  input  1  asynchronous active-low reset
- s_valid  input  N  per-requester valid; bit i = requester i
- s_data  input  N*DATA_W  packed payloads; requester i at [i*DATA_W +: DATA_W]
- s_ready  output  N  per-requester accept strobe, at most one bit high
- m_valid  output  1  downstream valid (registered)
- m_data  output  DATA_W  downstream payload (registered)
- m_id  output  ID_W  index of requester that produced m_data (registered)
- m_ready  input  1  downstream ready
- gnt_cnt  output  N*16  per-requester grant counters (only with ARB_GNT_CNT_EN)

Behaviour:
- Reset (async assert, sync-safe deassert by system):
  - m_valid=0, m_data=0, m_id=0
  - round-robin pointer rr_ptr=0
  - gnt_cnt all 0
  - s_ready=0 while sys_rst_n=0
- Load enable: load = !m_valid | m_ready (combinational). Output stage is empty, or is being drained this cycle.
- Winner selection (combinational): first set bit of s_valid searching i = rr_ptr, rr_ptr+1, ..., wrapping modulo N.
- s_ready[winner]=1 iff load=1 and |s_valid=1; all other s_ready bits 0. s_ready depends on m_ready combinationally; no combinational path from s_ready back to s_valid is permitted upstream.
- Accept (rising edge with load=1 and |s_valid=1):
  - m_data <= winner payload; m_id <= winner; m_valid <= 1
  - rr_ptr <= (winner+1) mod N
- Drain without refill (m_valid=1, m_ready=1, s_valid=0): m_valid <= 0. m_data/m_id hold their last value.
- Stall (m_valid=1, m_ready=0):
  - m_valid, m_data, m_id stable
  - all s_ready=0
  - rr_ptr unchanged
- Throughput: one transfer per cycle when m_ready is held high and any requester is valid.
- Latency: s_valid accepted at edge t gives m_valid=1 during cycle t+1.
- Requesters follow the codebase handshake rule: once s_valid[i]=1 it stays high with stable data until s_ready[i]=1 at an edge. The arbiter does not check this.
- Simultaneous drain and accept: the consumer takes the old word and the new word loads in the same edge, with no bubble.
- Fairness: a continuously requesting requester is granted within N accepts.
- rr_ptr values >= N cannot occur; the implementation wraps explicitly for non-power-of-2 N.
- Reset mid-transfer: pending m_valid is dropped (cleared to 0) and no s_ready is issued. Requesters re-present after reset.

Optional Feature:
- Macro ARB_GNT_CNT_EN.
- Defined:
  - Port gnt_cnt exists. Counter i increments by 1 on every accept of requester i and saturates at 16'hFFFF (no wrap).
  - Counters are cleared only by reset.
- Undefined: port gnt_cnt and all counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold sys_rst_n=0 with s_valid=4'b1111 -> m_valid=0, s_ready=0, m_id=0. Release -> first accept is requester 0, and m_valid=1 on the next cycle.
- Round-robin: s_valid=4'b1111 constant, s_data={3'd4,3'd3,3'd2,3'd1}, m_ready=1 -> m_id sequence 0,1,2,3,0,...; m_data 1,2,3,4,1,...; one word per cycle.
- Backpressure: m_valid=1 with m_id=2, m_data=3'd5, m_ready=0 for 5 cycles -> outputs stable and s_ready=0 throughout. Raise m_ready -> next requester (3, or wrap to 0) loads on the same edge.
- Sparse requests: only s_valid[1]=1 while rr_ptr=3 -> s_ready=4'b0010 immediately (wrap search), m_id=1, rr_ptr becomes 2.
- Async reset mid-stall: m_valid=1, m_ready=0, drop sys_rst_n between edges -> m_valid=0 immediately, without waiting for a clock edge.
- ARB_GNT_CNT_EN: 70000 accepts of requester 0 only -> gnt_cnt[15:0]=16'hFFFF and other counters 0. Without the macro, the bench compiles with no gnt_cnt port.
